conv_row_fetcher: RTL and testbench
===================================

# conv_row_fetcher

Consumer-side companion of `conv_router_v2`. Accepts one router window command (three input-row indices, column range, west/east padding) through a valid/ready handshake. Reads the referenced columns from the three-bank input feature-map buffer and emits one column beat per cycle, carrying the three rows side by side, with zero columns inserted for west/east padding and zero lanes for out-of-image rows. It sits between the router and the PE-array input registers.

## Interface
- `DATA_W`, 8, width of one feature-map element
- `ADDR_W`, 16, input buffer address width
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low; all state cleared while low
- `cmd_valid` in 1: command present
- `cmd_ready` out 1: block can accept a command
- `row_idx1`, `row_idx2`, `row_idx3` in 16: input rows for lanes 0/1/2; `16'hFFFF` marks a padding row
- `row_start_idx`, `row_end_idx` in 16: inclusive column range to read
- `west_pad`, `east_pad` in 4: zero columns before/after the body
- `ix` in 16: input row width in words (row pitch)
- `buf_rd_en` out 3: per-bank read enable, bit n = lane n
- `buf_rd_addr1`, `buf_rd_addr2`, `buf_rd_addr3` out ADDR_W: per-bank address
- `buf_rd_data` in 3*DATA_W: bank data; lane n at [n*DATA_W +: DATA_W], valid the cycle after `buf_rd_en`
- `px_valid` out 1, `px_ready` in 1: output handshake
- `px_data` out 3*DATA_W: column beat, same lane packing as `buf_rd_data`
- `px_last` out 1: marks the final beat of a command

## Operation
- States: IDLE, WEST, BODY, EAST, DRAIN.
- `cmd_ready` = 1 only in IDLE.
- Accept on `cmd_valid && cmd_ready`. At accept, latch all command fields and compute `base_n = row_idx_n * ix`, truncated to ADDR_W. Latch a per-lane pad flag `row_idx_n == 16'hFFFF`.
- Next state after accept: WEST if `west_pad != 0`; else BODY if `row_end_idx >= row_start_idx`; else EAST if `east_pad != 0`; else IDLE. A command with no columns produces no beats and no `px_last`.
- Column sequence:
  - WEST issues `west_pad` zero columns.
  - BODY issues columns `row_start_idx..row_end_idx` ascending, with address `base_n + col`.
  - EAST issues `east_pad` zero columns.
  - The same skip rule applies when leaving each state.
- An issue slot in BODY asserts `buf_rd_en[n]` only for non-pad lanes. WEST/EAST slots assert no `buf_rd_en`. Address outputs are 0 whenever their enable is low.
- Every issue, zero or read, passes through one pipeline stage so order is preserved. Pad lanes and pad columns are forced to zero at that stage.
- The final issued column carries a last tag. After it, go to DRAIN and stay there until the FIFO is empty with nothing in flight, then IDLE.
- Output buffer: 2-entry FIFO. Issue is allowed when `fifo_count + inflight - pop < 2`, where pop = `px_valid && px_ready`. This sustains 1 beat/cycle with `px_ready` high and never overflows.
- Arithmetic: the column counter is 16 bits and pad counters are 4 bits. Address sums wrap modulo 2^ADDR_W.

## Timing
- Reset values:
  - `cmd_ready` = 0 while `reset` is low, then 1 (IDLE).
  - `buf_rd_en` = 0, all `buf_rd_addr` = 0.
  - `px_valid` = 0, `px_data` = 0, `px_last` = 0.
  - FIFO and in-flight state empty.
- Command accepted at edge T:
  - First issue in cycle T+1.
  - Bank data returns in T+2 and is written to the FIFO at the end of T+2.
  - First `px_valid` in T+3. Pad-column beats use the same latency.
- Steady state: one beat per cycle while `px_ready` = 1.
- While `px_valid && !px_ready`, `px_data` and `px_last` hold stable. At most one further issue occurs after the stall begins, and no beat is lost or duplicated.
- `cmd_ready` reasserts the cycle after DRAIN completes. Minimum command-to-command spacing is N+3 cycles for N beats.
- `reset` asserted mid-command: outputs go to reset values immediately. In-flight data is discarded and the FIFO is flushed. No partial `px_last` appears after release.

## Test plan
- Basic window. Stimulus: `ix`=128, rows 10/11/12, start 0, end 3, west 2, east 1, `px_ready`=1. Required: 7 beats.
  - Beats 0–1 are zero.
  - Beats 2–5 carry lanes from addresses 1280+c, 1408+c, 1536+c for c=0..3.
  - Beat 6 is zero with `px_last`=1. First `px_valid` appears 3 cycles after accept.
- Padding row. Same command with `row_idx3`=`16'hFFFF`. Required: `buf_rd_en[2]` never asserts, lane 2 is zero on all beats, lanes 0–1 are unchanged.
- Backpressure. Basic window with `px_ready` low for 5 cycles after beat 3. Required: beat 3 is held stable, the buffer never issues more than one read beyond the stall, the order is intact, and there are still exactly 7 beats.
- Empty command. west 0, east 0, start 5, end 4. Required: no `buf_rd_en`, no `px_valid`, and `cmd_ready` high again 1 cycle after accept.
- Back-to-back. Two commands held valid. Required: `cmd_ready` stays low from accept until the first command's `px_last` drains, and the second command's beats follow with no interleaving.
- Reset mid-stream. Assert `reset` low during beat 4 of the basic window. Required: all outputs are 0 while low. After release, `cmd_ready` = 1 and no stale beat appears.

Source files
------------

// File: rtl/conv_row_fetcher_if.sv
// Bundles the router command, input-buffer read port and PE-side pixel stream
// of conv_row_fetcher. master = the fetcher, slave = the surrounding fabric.
interface conv_row_fetcher_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [15:0]           row_idx1;
    logic [15:0]           row_idx2;
    logic [15:0]           row_idx3;
    logic [15:0]           row_start_idx;
    logic [15:0]           row_end_idx;
    logic [3:0]            west_pad;
    logic [3:0]            east_pad;
    logic [15:0]           ix;

    logic [2:0]            buf_rd_en;
    logic [ADDR_W-1:0]     buf_rd_addr1;
    logic [ADDR_W-1:0]     buf_rd_addr2;
    logic [ADDR_W-1:0]     buf_rd_addr3;
    logic [3*DATA_W-1:0]   buf_rd_data;

    logic                  px_valid;
    logic                  px_ready;
    logic [3*DATA_W-1:0]   px_data;
    logic                  px_last;

    modport master (
        input  cmd_valid, row_idx1, row_idx2, row_idx3, row_start_idx,
               row_end_idx, west_pad, east_pad, ix, buf_rd_data, px_ready,
        output cmd_ready, buf_rd_en, buf_rd_addr1, buf_rd_addr2, buf_rd_addr3,
               px_valid, px_data, px_last
    );

    modport slave (
        output cmd_valid, row_idx1, row_idx2, row_idx3, row_start_idx,
               row_end_idx, west_pad, east_pad, ix, buf_rd_data, px_ready,
        input  cmd_ready, buf_rd_en, buf_rd_addr1, buf_rd_addr2, buf_rd_addr3,
               px_valid, px_data, px_last
    );
endinterface

// File: rtl/conv_row_fetcher.sv
// Turns one router window command into a stream of 3-row column beats read
// from the three-bank input buffer, with zero padding columns and rows.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WEST  | issuing west_pad zero columns
// BODY  | issuing buffer reads for columns row_start_idx..row_end_idx
// EAST  | issuing east_pad zero columns
// DRAIN | last column issued, waiting for pipeline and FIFO to empty
module conv_row_fetcher #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    conv_row_fetcher_if.master bus
);
    localparam int BEAT_W = 3 * DATA_W;

    typedef enum logic [2:0] {IDLE, WEST, BODY, EAST, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              run_q;

    logic [ADDR_W-1:0] base1_q, base2_q, base3_q;
    logic [2:0]        lane_pad_q;
    logic [15:0]       end_q;
    logic [3:0]        east_q;
    logic              has_body_q;
    logic [15:0]       col_q, col_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              accept;
    logic              issue;
    logic              issue_pad;
    logic              issue_last;
    logic [2:0]        rd_en;

    logic              s1_valid;
    logic              s1_pad;
    logic              s1_last;
    logic [2:0]        s1_lane_pad;
    logic [BEAT_W-1:0] beat;

    logic [BEAT_W:0]   fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_count, fifo_count_d;
    logic              push, pop;
    logic [2:0]        occ;
    logic              can_issue;
    logic [BEAT_W:0]   head;

    assign push = s1_valid;
    assign pop  = (fifo_count != 2'd0) && bus.px_ready;

    // Occupancy after this cycle's pop, counting the beat still in the read stage.
    assign occ       = {1'b0, fifo_count} + {2'b00, s1_valid} - {2'b00, pop};
    assign can_issue = (occ < 3'd2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        issue      = 1'b0;
        issue_pad  = 1'b0;
        issue_last = 1'b0;
        rd_en      = 3'b000;
        case (state_q)
            IDLE: begin
                if (run_q && bus.cmd_valid) begin
                    accept = 1'b1;
                    col_d  = bus.row_start_idx;
                    if (bus.west_pad != 4'd0) begin
                        state_d = WEST;
                        cnt_d   = bus.west_pad;
                    end else if (bus.row_end_idx >= bus.row_start_idx) begin
                        state_d = BODY;
                    end else if (bus.east_pad != 4'd0) begin
                        state_d = EAST;
                        cnt_d   = bus.east_pad;
                    end
                end
            end
            WEST: begin
                if (can_issue) begin
                    issue     = 1'b1;
                    issue_pad = 1'b1;
                    if (cnt_q == 4'd1) begin
                        if (has_body_q) begin
                            state_d = BODY;
                        end else if (east_q != 4'd0) begin
                            state_d = EAST;
                            cnt_d   = east_q;
                        end else begin
                            issue_last = 1'b1;
                            state_d    = DRAIN;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            BODY: begin
                if (can_issue) begin
                    issue = 1'b1;
                    rd_en = ~lane_pad_q;
                    // Terminal compare before increment so end = 16'hFFFF never wraps.
                    if (col_q == end_q) begin
                        if (east_q != 4'd0) begin
                            state_d = EAST;
                            cnt_d   = east_q;
                        end else begin
                            issue_last = 1'b1;
                            state_d    = DRAIN;
                        end
                    end else begin
                        col_d = col_q + 16'd1;
                    end
                end
            end
            EAST: begin
                if (can_issue) begin
                    issue     = 1'b1;
                    issue_pad = 1'b1;
                    if (cnt_q == 4'd1) begin
                        issue_last = 1'b1;
                        state_d    = DRAIN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (!s1_valid && (fifo_count == {1'b0, pop})) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base1_q    <= '0;
            base2_q    <= '0;
            base3_q    <= '0;
            lane_pad_q <= 3'b000;
            end_q      <= 16'd0;
            east_q     <= 4'd0;
            has_body_q <= 1'b0;
            col_q      <= 16'd0;
            cnt_q      <= 4'd0;
        end else begin
            col_q <= col_d;
            cnt_q <= cnt_d;
            if (accept) begin
                base1_q    <= ADDR_W'(32'(bus.row_idx1) * 32'(bus.ix));
                base2_q    <= ADDR_W'(32'(bus.row_idx2) * 32'(bus.ix));
                base3_q    <= ADDR_W'(32'(bus.row_idx3) * 32'(bus.ix));
                lane_pad_q <= {bus.row_idx3 == 16'hFFFF,
                               bus.row_idx2 == 16'hFFFF,
                               bus.row_idx1 == 16'hFFFF};
                end_q      <= bus.row_end_idx;
                east_q     <= bus.east_pad;
                has_body_q <= (bus.row_end_idx >= bus.row_start_idx);
            end
        end
    end

    assign bus.cmd_ready    = run_q && (state_q == IDLE);
    assign bus.buf_rd_en    = rd_en;
    assign bus.buf_rd_addr1 = rd_en[0] ? base1_q + ADDR_W'(col_q) : '0;
    assign bus.buf_rd_addr2 = rd_en[1] ? base2_q + ADDR_W'(col_q) : '0;
    assign bus.buf_rd_addr3 = rd_en[2] ? base3_q + ADDR_W'(col_q) : '0;

    // Read stage: zero and read issues share it so beat order matches issue order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid    <= 1'b0;
            s1_pad      <= 1'b0;
            s1_last     <= 1'b0;
            s1_lane_pad <= 3'b000;
        end else begin
            s1_valid    <= issue;
            s1_pad      <= issue_pad;
            s1_last     <= issue_last;
            s1_lane_pad <= lane_pad_q;
        end
    end

    always_comb begin
        beat = '0;
        for (int n = 0; n < 3; n++) begin
            if (!(s1_pad || s1_lane_pad[n])) begin
                beat[n*DATA_W +: DATA_W] = bus.buf_rd_data[n*DATA_W +: DATA_W];
            end
        end
    end

    assign fifo_count_d = fifo_count + {1'b0, push} - {1'b0, pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {s1_last, beat};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count_d;
        end
    end

    assign head         = fifo_mem[rd_ptr];
    assign bus.px_valid = (fifo_count != 2'd0);
    assign bus.px_data  = bus.px_valid ? head[BEAT_W-1:0] : '0;
    assign bus.px_last  = bus.px_valid && head[BEAT_W];
endmodule

// File: tb/tb_conv_row_fetcher.sv
// Directed bench for conv_row_fetcher: table of window commands with
// hand-computed beats, plus stall, back-to-back and mid-stream reset cases.
module tb_conv_row_fetcher;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    conv_row_fetcher_if #(.DATA_W(8), .ADDR_W(16)) bus ();

    conv_row_fetcher #(.DATA_W(8), .ADDR_W(16)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer bank model: content is a function of address and lane; idle lanes return junk.
    function automatic logic [7:0] memf(input logic [15:0] a, input int lane);
        return a[7:0] + a[15:8] + 8'(lane * 16);
    endfunction

    logic [7:0] rq0, rq1, rq2;
    always @(posedge clk) begin
        rq0 <= bus.buf_rd_en[0] ? memf(bus.buf_rd_addr1, 0) : 8'hEE;
        rq1 <= bus.buf_rd_en[1] ? memf(bus.buf_rd_addr2, 1) : 8'hEE;
        rq2 <= bus.buf_rd_en[2] ? memf(bus.buf_rd_addr3, 2) : 8'hEE;
    end
    assign bus.buf_rd_data = {rq2, rq1, rq0};

    int          acc[$];
    logic [23:0] bq_data[$];
    logic        bq_last[$];
    int          bq_cyc[$];
    int          rd_cnt;
    logic [2:0]  rd_or;
    int          addr_bad;
    bit          pxv_seen;

    always @(negedge clk) begin
        if (bus.cmd_valid && bus.cmd_ready) acc.push_back(cyc);
        if (bus.px_valid && bus.px_ready) begin
            bq_data.push_back(bus.px_data);
            bq_last.push_back(bus.px_last);
            bq_cyc.push_back(cyc);
        end
        if (bus.px_valid) pxv_seen = 1'b1;
        if (bus.buf_rd_en != 3'b000) rd_cnt++;
        rd_or = rd_or | bus.buf_rd_en;
        if (!bus.buf_rd_en[0] && bus.buf_rd_addr1 != 16'd0) addr_bad++;
        if (!bus.buf_rd_en[1] && bus.buf_rd_addr2 != 16'd0) addr_bad++;
        if (!bus.buf_rd_en[2] && bus.buf_rd_addr3 != 16'd0) addr_bad++;
    end

    task automatic clear_mon();
        acc.delete();
        bq_data.delete();
        bq_last.delete();
        bq_cyc.delete();
        rd_cnt   = 0;
        rd_or    = 3'b000;
        addr_bad = 0;
        pxv_seen = 1'b0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct packed {
        logic [15:0]      ix;
        logic [15:0]      r1;
        logic [15:0]      r2;
        logic [15:0]      r3;
        logic [15:0]      cs;
        logic [15:0]      ce;
        logic [3:0]       w;
        logic [3:0]       e;
        logic [3:0]       n;
        logic [3:0]       nreads;
        logic [2:0]       lanes;
        logic [7:0][23:0] exp;
    } vec_t;

    vec_t vt [7];

    function automatic vec_t mk(input logic [15:0] ix, r1, r2, r3, cs, ce,
                                input logic [3:0] w, e, n, nr, input logic [2:0] ln);
        vec_t v;
        v.ix = ix; v.r1 = r1; v.r2 = r2; v.r3 = r3; v.cs = cs; v.ce = ce;
        v.w = w; v.e = e; v.n = n; v.nreads = nr; v.lanes = ln;
        v.exp = '0;
        return v;
    endfunction

    task automatic drive(input int i);
        bus.ix            = vt[i].ix;
        bus.row_idx1      = vt[i].r1;
        bus.row_idx2      = vt[i].r2;
        bus.row_idx3      = vt[i].r3;
        bus.row_start_idx = vt[i].cs;
        bus.row_end_idx   = vt[i].ce;
        bus.west_pad      = vt[i].w;
        bus.east_pad      = vt[i].e;
    endtask

    task automatic check_beats(input string tag, input int i, input int first);
        int n;
        n = int'(vt[i].n);
        for (int k = 0; k < n; k++) begin
            if (first + k < bq_data.size()) begin
                chk($sformatf("%s_data%0d", tag, k), 32'(bq_data[first + k]), 32'(vt[i].exp[k]));
                chk($sformatf("%s_last%0d", tag, k), 32'(bq_last[first + k]), (k == n - 1) ? 32'd1 : 32'd0);
            end
        end
    endtask

    task automatic run_vec(input int i);
        int t;
        int rc;
        int a0;
        int n;
        n = int'(vt[i].n);
        clear_mon();
        @(posedge clk); #1;
        drive(i);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        rc = -1;
        t  = 0;
        while (rc < 0 && t < 60) begin
            @(negedge clk);
            if (bus.cmd_ready) rc = cyc;
            t++;
        end
        repeat (4) @(negedge clk);
        chk($sformatf("v%0d_accepts", i), 32'(acc.size()), 32'd1);
        a0 = (acc.size() > 0) ? acc[0] : 0;
        chk($sformatf("v%0d_ready_back", i), 32'(rc - a0), (n == 0) ? 32'd1 : 32'(n + 3));
        chk($sformatf("v%0d_beats", i), 32'(bq_data.size()), 32'(n));
        check_beats($sformatf("v%0d", i), i, 0);
        if (n > 0 && bq_cyc.size() > 0)
            chk($sformatf("v%0d_latency", i), 32'(bq_cyc[0] - a0), 32'd3);
        chk($sformatf("v%0d_reads", i), 32'(rd_cnt), 32'(vt[i].nreads));
        chk($sformatf("v%0d_lanes", i), 32'(rd_or), 32'(vt[i].lanes));
        chk($sformatf("v%0d_addr_zero", i), 32'(addr_bad), 32'd0);
    endtask

    initial begin
        int t;
        int rd_at;
        int stall_bad;
        logic [23:0] held;

        checks   = 0;
        failures = 0;
        cyc      = 0;

        // ix, rows, start, end, west, east, beats, read cycles, lanes read
        vt[0] = mk(16'd128, 16'd10, 16'd11, 16'd12, 16'd0, 16'd3, 4'd2, 4'd1, 4'd7, 4'd4, 3'b111);
        for (int c = 0; c < 4; c++)
            vt[0].exp[2 + c] = {8'(8'h26 + c), 8'(8'h95 + c), 8'(8'h05 + c)};
        vt[1] = mk(16'd128, 16'd10, 16'd11, 16'hFFFF, 16'd0, 16'd3, 4'd2, 4'd1, 4'd7, 4'd4, 3'b011);
        for (int c = 0; c < 4; c++)
            vt[1].exp[2 + c] = {8'h00, 8'(8'h95 + c), 8'(8'h05 + c)};
        vt[2] = mk(16'd128, 16'd1, 16'd2, 16'd3, 16'd5, 16'd4, 4'd0, 4'd0, 4'd0, 4'd0, 3'b000);
        vt[3] = mk(16'd4, 16'd1, 16'd2, 16'd3, 16'd1, 16'd0, 4'd3, 4'd0, 4'd3, 4'd0, 3'b000);
        vt[4] = mk(16'd7, 16'd0, 16'd1, 16'd2, 16'd2, 16'd2, 4'd0, 4'd0, 4'd1, 4'd1, 3'b111);
        vt[4].exp[0] = {8'h30, 8'h19, 8'h02};
        vt[5] = mk(16'd4, 16'd1, 16'd2, 16'd3, 16'd3, 16'd2, 4'd0, 4'd2, 4'd2, 4'd0, 3'b000);
        vt[6] = mk(16'h1000, 16'd16, 16'd17, 16'd15, 16'hFFFE, 16'hFFFF, 4'd0, 4'd0, 4'd2, 4'd2, 3'b111);
        vt[6].exp[0] = {8'h0D, 8'h1D, 8'hFD};
        vt[6].exp[1] = {8'h0E, 8'h1E, 8'hFE};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.px_ready  = 1'b1;
        drive(2);
        clear_mon();

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rd_en", 32'(bus.buf_rd_en), 32'd0);
        chk("rst_addr", 32'({bus.buf_rd_addr1, bus.buf_rd_addr2} | 32'(bus.buf_rd_addr3)), 32'd0);
        chk("rst_px", 32'({bus.px_valid, bus.px_last, bus.px_data}), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_vec(i);

        // Backpressure: hold beat 3 for 5 cycles.
        clear_mon();
        @(posedge clk); #1;
        drive(0);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        t = 0;
        while (bq_data.size() < 3 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        bus.px_ready = 1'b0;
        held      = bus.px_data;
        rd_at     = rd_cnt;
        stall_bad = 0;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (!bus.px_valid || bus.px_data !== held || bus.px_last !== 1'b0) stall_bad++;
        end
        chk("bp_held_value", 32'(held), 32'(vt[0].exp[3]));
        chk("bp_stable", 32'(stall_bad), 32'd0);
        chk("bp_reads_in_stall_le1", 32'((rd_cnt - rd_at) <= 1), 32'd1);
        @(posedge clk); #1;
        bus.px_ready = 1'b1;
        t = 0;
        while ((bq_data.size() < 7 || !bus.cmd_ready) && t < 80) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("bp_beats", 32'(bq_data.size()), 32'd7);
        check_beats("bp", 0, 0);

        // Back-to-back: command held valid, fields switched after first accept.
        clear_mon();
        @(posedge clk); #1;
        drive(0);
        bus.cmd_valid = 1'b1;
        t = 0;
        while (acc.size() < 1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        drive(4);
        t = 0;
        while (acc.size() < 2 && t < 60) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        t = 0;
        while ((bq_data.size() < 8 || !bus.cmd_ready) && t < 60) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("b2b_accepts", 32'(acc.size()), 32'd2);
        chk("b2b_beats", 32'(bq_data.size()), 32'd8);
        if (acc.size() >= 2) begin
            chk("b2b_spacing", 32'(acc[1] - acc[0]), 32'd10);
            if (bq_cyc.size() >= 8) begin
                chk("b2b_after_last", 32'(acc[1] - bq_cyc[6]), 32'd1);
                chk("b2b_second_latency", 32'(bq_cyc[7] - acc[1]), 32'd3);
            end
        end
        check_beats("b2b_a", 0, 0);
        check_beats("b2b_b", 4, 7);

        // Reset during beat 4.
        clear_mon();
        @(posedge clk); #1;
        drive(0);
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        t = 0;
        while (bq_data.size() < 4 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_px", 32'({bus.px_valid, bus.px_last, bus.px_data}), 32'd0);
        chk("mid_rst_ctrl", 32'({bus.cmd_ready, bus.buf_rd_en}), 32'd0);
        chk("mid_rst_addr", 32'({bus.buf_rd_addr1, bus.buf_rd_addr2} | 32'(bus.buf_rd_addr3)), 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_hold", 32'({bus.px_valid, bus.cmd_ready}), 32'd0);
        clear_mon();
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rel_no_stale_valid", 32'(pxv_seen), 32'd0);
        chk("rel_no_reads", 32'(rd_cnt), 32'd0);

        run_vec(4);
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
